// File: rtl/fifo_pkg.sv
// Shared FIFO constants and wrap-bit pointer compares, reused by the sync and async FIFOs.
package fifo_pkg;
   localparam int FIFO_MODE_STD   = 0;
   localparam int FIFO_MODE_FWFT  = 1;
   localparam int FIFO_DATA_WIDTH = 16;
   localparam int FIFO_ADDR_WIDTH = 6;

   // Pointers are aw address bits plus one wrap bit at position aw.
   function automatic logic ptr_full(input logic [31:0] wptr, input logic [31:0] rptr,
                                     input logic [4:0] aw);
      logic [31:0] diff;
      diff = wptr ^ rptr;
      return diff[aw] && ((diff & ((32'd1 << aw) - 32'd1)) == 32'd0);
   endfunction

   function automatic logic ptr_empty(input logic [31:0] wptr, input logic [31:0] rptr,
                                      input logic [4:0] aw);
      return ((wptr ^ rptr) & ((32'd2 << aw) - 32'd1)) == 32'd0;
   endfunction
endpackage

// File: rtl/fifo_dual_port_ram.sv
// Simple dual-port RAM: synchronous write, read port registered or combinational.
module fifo_dual_port_ram import fifo_pkg::*; #(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
   parameter bit REG_READ   = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  read_enable,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] read_data
);
   // Storage is deliberately left uninitialised on reset.
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clock)
      if (write_enable) mem[write_addr] <= write_data;

   generate
      if (REG_READ) begin : g_reg
         always_ff @(posedge clock or posedge reset)
            if (reset)            read_data <= '0;
            else if (read_enable) read_data <= mem[read_addr];
      end else begin : g_comb
         logic unused_ok;
         assign unused_ok = ^{reset, read_enable};
         assign read_data = mem[read_addr];
      end
   endgenerate
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with optional first-word-fall-through, level and error flags.
module sync_fifo_param import fifo_pkg::*; #(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
   parameter int FWFT       = FIFO_MODE_STD,
   parameter int AF_THRESH  = 56,
   parameter int AE_THRESH  = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_enable,
   input  logic                  read_enable,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   fill_level,
   output logic                  overflow,
   output logic                  underflow
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

   logic [PW-1:0]         wptr, rptr, wptr_nxt, rptr_nxt, fill_nxt;
   logic                  push, pop;
   logic [DATA_WIDTH-1:0] ram_q;

   assign push     = write_enable & ~full;
   assign pop      = read_enable & ~empty;
   assign wptr_nxt = wptr + PW'(push);
   assign rptr_nxt = rptr + PW'(pop);
   assign fill_nxt = wptr_nxt - rptr_nxt;

   // Flags are computed from next-state pointers so they track fill_level on the same edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr         <= '0;
         rptr         <= '0;
         fill_level   <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wptr         <= wptr_nxt;
         rptr         <= rptr_nxt;
         fill_level   <= fill_nxt;
         full         <= ptr_full(32'(wptr_nxt), 32'(rptr_nxt), 5'(ADDR_WIDTH));
         empty        <= ptr_empty(32'(wptr_nxt), 32'(rptr_nxt), 5'(ADDR_WIDTH));
         almost_full  <= fill_nxt >= AF_LVL;
         almost_empty <= fill_nxt <= AE_LVL;
         overflow     <= write_enable & full;
         underflow    <= read_enable & empty;
      end
   end

   fifo_dual_port_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .REG_READ   (FWFT == FIFO_MODE_STD)
   ) u_ram (
      .clock        (clock),
      .reset        (reset),
      .write_enable (push),
      .write_addr   (wptr[ADDR_WIDTH-1:0]),
      .write_data   (write_data),
      .read_enable  (pop),
      .read_addr    (rptr[ADDR_WIDTH-1:0]),
      .read_data    (ram_q)
   );

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
         // Head word is shown only while something is stored, so reset forces zero.
         assign read_valid = ~empty;
         assign read_data  = empty ? '0 : ram_q;
      end else begin : g_std
         always_ff @(posedge clock or posedge reset)
            if (reset) read_valid <= 1'b0;
            else       read_valid <= pop;
         assign read_data = ram_q;
      end
   endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed scoreboard bench for sync_fifo_param, standard and FWFT instances.
module tb_sync_fifo_param;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] write_data = '0;
   logic        write_enable = 1'b0, read_enable = 1'b0;
   logic [15:0] read_data;
   logic        read_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [6:0]  fill_level;

   logic [15:0] f_wd = '0;
   logic        f_we = 1'b0, f_re = 1'b0;
   logic [15:0] f_rd;
   logic        f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [6:0]  f_fill;

   int total = 0;
   int bad   = 0;
   logic [15:0] model[$];
   logic [15:0] exp_q[$];

   always #5 clock = ~clock;

   sync_fifo_param #(.FWFT(0)) dut (
      .clock(clock), .reset(reset), .write_data(write_data), .write_enable(write_enable),
      .read_enable(read_enable), .read_data(read_data), .read_valid(read_valid), .full(full),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .fill_level(fill_level), .overflow(overflow), .underflow(underflow));

   sync_fifo_param #(.FWFT(1)) dut_fwft (
      .clock(clock), .reset(reset), .write_data(f_wd), .write_enable(f_we),
      .read_enable(f_re), .read_data(f_rd), .read_valid(f_rv), .full(f_full),
      .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
      .fill_level(f_fill), .overflow(f_ovf), .underflow(f_udf));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model decides acceptance from pre-edge occupancy; popped words go to the scoreboard.
   task automatic step(input logic we, input logic [15:0] wd, input logic re);
      logic acc_pop, acc_push;
      acc_pop  = re && (model.size() != 0);
      acc_push = we && (model.size() != 64);
      if (acc_pop)  exp_q.push_back(model.pop_front());
      if (acc_push) model.push_back(wd);
      write_enable = we; write_data = wd; read_enable = re;
      @(posedge clock); #1;
      write_enable = 1'b0; read_enable = 1'b0;
   endtask

   // Monitor: every read_valid must match the oldest outstanding expected word.
   always @(negedge clock) begin
      if (!reset && read_valid) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected: got %0h expected none at %0t", read_data, $time);
         end else begin
            chk("rd_data", 32'(read_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_fill", 32'(fill_level), 0);
      chk("rst_flags_ae_af", 32'({almost_empty, almost_full}), 2);
      chk("rst_rv_rd", 32'({read_valid, read_data}), 0);
      chk("rst_err", 32'({overflow, underflow}), 0);
      reset = 1'b0;

      // 1: reset mid-stream
      for (int i = 0; i < 5; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0);
      chk("t1_fill5", 32'(fill_level), 5);
      reset = 1'b1;
      #2;
      chk("t1_rst_empty", 32'(empty), 1);
      chk("t1_rst_fill", 32'(fill_level), 0);
      chk("t1_rst_rv", 32'(read_valid), 0);
      model.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      step(1'b0, 16'h0, 1'b1);
      chk("t1_underflow", 32'(underflow), 1);
      chk("t1_udf_rv", 32'(read_valid), 0);
      step(1'b0, 16'h0, 1'b0);
      chk("t1_udf_pulse_end", 32'(underflow), 0);

      // 2: fill, overflow, drain
      for (int i = 0; i < 64; i++) begin
         step(1'b1, 16'(i), 1'b0);
         if (i == 54) chk("t2_af_at55", 32'(almost_full), 0);
         if (i == 55) chk("t2_af_at56", 32'(almost_full), 1);
         if (i == 62) chk("t2_full_at63", 32'(full), 0);
      end
      chk("t2_full", 32'(full), 1);
      chk("t2_fill64", 32'(fill_level), 64);
      step(1'b1, 16'hDEAD, 1'b0);
      chk("t2_overflow", 32'(overflow), 1);
      chk("t2_fill_hold", 32'(fill_level), 64);
      step(1'b0, 16'h0, 1'b0);
      chk("t2_ovf_pulse_end", 32'(overflow), 0);
      for (int i = 0; i < 64; i++) begin
         step(1'b0, 16'h0, 1'b1);
         if (i == 54) chk("t2_ae_at9", 32'(almost_empty), 0);
         if (i == 55) chk("t2_ae_at8", 32'(almost_empty), 1);
      end
      chk("t2_drained", 32'(empty), 1);
      step(1'b0, 16'h0, 1'b0);

      // 3: simultaneous push+pop at level 32, pointers wrap
      for (int i = 0; i < 32; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 16'h0200 + 16'(i), 1'b1);
         chk("t3_fill32", 32'(fill_level), 32);
         chk("t3_flags", 32'({full, empty, almost_full, almost_empty}), 0);
      end
      for (int i = 0; i < 32; i++) step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b0);

      // 4: full + push + pop
      for (int i = 0; i < 64; i++) step(1'b1, 16'h0300 + 16'(i), 1'b0);
      step(1'b1, 16'hBEEF, 1'b1);
      chk("t4_fill63", 32'(fill_level), 63);
      chk("t4_overflow", 32'(overflow), 1);
      chk("t4_not_full", 32'(full), 0);
      for (int i = 0; i < 63; i++) step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b0);
      chk("t4_empty", 32'(empty), 1);

      // 5: empty + push + pop
      step(1'b1, 16'h5555, 1'b1);
      chk("t5_fill1", 32'(fill_level), 1);
      chk("t5_underflow", 32'(underflow), 1);
      chk("t5_rv", 32'(read_valid), 0);
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b0);

      // 6: FWFT visibility vs standard read latency
      chk("t6_fwft_idle", 32'({f_rv, f_rd}), 0);
      f_we = 1'b1; f_wd = 16'h1234;
      @(posedge clock); #1;
      f_we = 1'b0;
      chk("t6_fwft_rv", 32'(f_rv), 1);
      chk("t6_fwft_rd", 32'(f_rd), 32'h1234);
      f_re = 1'b1;
      @(posedge clock); #1;
      f_re = 1'b0;
      chk("t6_fwft_consumed", 32'({f_rv, f_empty}), 1);
      step(1'b1, 16'h1234, 1'b0);
      chk("t6_std_no_rv", 32'(read_valid), 0);
      step(1'b0, 16'h0, 1'b1);
      chk("t6_std_rv", 32'(read_valid), 1);
      chk("t6_std_rd", 32'(read_data), 32'h1234);
      step(1'b0, 16'h0, 1'b0);
      chk("t6_std_rv_drop", 32'(read_valid), 0);

      repeat (2) @(posedge clock);
      #1;
      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
